// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode. It absorbs decode stalls
// and refuses further fetches after a faulting instruction until the ROB flushes.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  input  logic                       fetch_error,
  input  logic [30:0]                fetch_addr,
  input  logic [31:0]                fetch_insn,
  input  logic [15:0]                fetch_bptag,
  input  logic                       fetch_bptaken,
  output logic                       fq_stall,
  output logic                       fq_de_valid,
  output logic                       fq_de_error,
  output logic [30:0]                fq_de_addr,
  output logic [31:0]                fq_de_insn,
  output logic [15:0]                fq_de_bptag,
  output logic                       fq_de_bptaken,
  input  logic                       decode_stall,
  input  logic                       rob_flush,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        error;
    logic [30:0] addr;
    logic [31:0] insn;
    logic [15:0] bptag;
    logic        bptaken;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              blocked_q, blocked_d;
  logic              full, push, pop;
  entry_t            wr_entry, head_entry;

  // Stall depends on registered state only, so a pop cannot free a slot for
  // a push in the same cycle.
  assign full     = (count_q == CntW'(DEPTH));
  assign fq_stall = full | blocked_q;
  assign push     = fetch_valid & ~fq_stall & ~rob_flush;
  assign pop      = fq_de_valid & ~decode_stall & ~rob_flush;

  assign wr_entry = '{error:   fetch_error,
                      addr:    fetch_addr,
                      insn:    fetch_insn,
                      bptag:   fetch_bptag,
                      bptaken: fetch_bptaken};

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    blocked_d = blocked_q;
    if (rob_flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      blocked_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PtrW'(1);
        if (fetch_error) blocked_d = 1'b1;
      end
      if (pop) head_d = head_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      blocked_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      blocked_q <= blocked_d;
      if (push) mem_q[tail_q] <= wr_entry;
    end
  end

  assign head_entry    = mem_q[head_q];
  assign fq_de_valid   = (count_q != '0);
  assign fq_de_error   = head_entry.error;
  assign fq_de_addr    = head_entry.addr;
  assign fq_de_insn    = head_entry.insn;
  assign fq_de_bptag   = head_entry.bptag;
  assign fq_de_bptaken = head_entry.bptaken;
  assign fq_count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a driver pushes expected entries as they are
// accepted, a monitor pops and compares whenever decode takes the head.
module tb_fetch_queue;

  typedef struct packed {
    logic        error;
    logic [30:0] addr;
    logic [31:0] insn;
    logic [15:0] bptag;
    logic        bptaken;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_error = 1'b0;
  logic [30:0] fetch_addr = '0;
  logic [31:0] fetch_insn = '0;
  logic [15:0] fetch_bptag = '0;
  logic        fetch_bptaken = 1'b0;
  logic        fq_stall, fq_de_valid, fq_de_error, fq_de_bptaken;
  logic [30:0] fq_de_addr;
  logic [31:0] fq_de_insn;
  logic [15:0] fq_de_bptag;
  logic        decode_stall = 1'b0;
  logic        rob_flush = 1'b0;
  logic [2:0]  fq_count;

  int errors = 0;
  int checks = 0;
  entry_t sb[$];
  int m_cnt = 0;
  logic m_blk = 1'b0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_error(fetch_error), .fetch_addr(fetch_addr),
    .fetch_insn(fetch_insn), .fetch_bptag(fetch_bptag), .fetch_bptaken(fetch_bptaken),
    .fq_stall(fq_stall), .fq_de_valid(fq_de_valid), .fq_de_error(fq_de_error),
    .fq_de_addr(fq_de_addr), .fq_de_insn(fq_de_insn), .fq_de_bptag(fq_de_bptag),
    .fq_de_bptaken(fq_de_bptaken), .decode_stall(decode_stall), .rob_flush(rob_flush),
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge when valid, not stalled, not flushed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fq_de_valid && !decode_stall && !rob_flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got insn %h expected none", fq_de_insn);
        end else begin
          check("head_entry",
                {fq_de_error, fq_de_addr, fq_de_insn, fq_de_bptag, fq_de_bptaken},
                sb.pop_front());
        end
      end
    end
  end

  // One cycle: drive, check state against the model mid-cycle, then advance model.
  task automatic step(input logic fv, input logic err, input logic [30:0] addr,
                      input logic [31:0] insn, input logic ds, input logic fl);
    logic push, pop;
    fetch_valid   = fv;
    fetch_error   = err;
    fetch_addr    = addr;
    fetch_insn    = insn;
    fetch_bptag   = insn[15:0] ^ 16'hA5A5;
    fetch_bptaken = insn[7];
    decode_stall  = ds;
    rob_flush     = fl;
    @(negedge clk);
    check("fq_count", 81'(fq_count), 81'(m_cnt));
    check("fq_stall", 81'(fq_stall), 81'((m_cnt == 4) || m_blk));
    check("fq_de_valid", 81'(fq_de_valid), 81'(m_cnt != 0));
    push = fv && !((m_cnt == 4) || m_blk) && !fl;
    pop  = (m_cnt != 0) && !ds && !fl;
    if (push) sb.push_back('{err, addr, insn, insn[15:0] ^ 16'hA5A5, insn[7]});
    @(posedge clk);
    #1;
    if (fl) begin
      m_cnt = 0;
      m_blk = 1'b0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (push && err) m_blk = 1'b1;
    end
  endtask

  task automatic idle(input logic ds);
    step(1'b0, 1'b0, 31'h0, 32'h0, ds, 1'b0);
  endtask

  initial begin
    // 1. Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 81'(fq_de_valid), 81'(0));
    check("rst_stall", 81'(fq_stall), 81'(0));
    check("rst_count", 81'(fq_count), 81'(0));
    check("rst_insn", 81'(fq_de_insn), 81'(0));
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // 2. Fill with decode stalled
    step(1'b1, 1'b0, 31'h10, 32'h00000013, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h12, 32'h00100093, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h14, 32'h00200113, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h16, 32'h00300193, 1'b1, 1'b0);
    check("fill_count", 81'(fq_count), 81'(4));
    check("fill_stall", 81'(fq_stall), 81'(1));
    check("fill_head", 81'(fq_de_insn), 81'(32'h00000013));
    step(1'b1, 1'b0, 31'h18, 32'h00400213, 1'b1, 1'b0);
    check("fill_5th_refused", 81'(fq_count), 81'(4));

    // 3. Full with pop: first offer refused, re-offer accepted
    step(1'b1, 1'b0, 31'h18, 32'h00400213, 1'b0, 1'b0);
    check("fullpop_count", 81'(fq_count), 81'(3));
    step(1'b1, 1'b0, 31'h18, 32'h00400213, 1'b0, 1'b0);
    check("fullpop_accept", 81'(fq_count), 81'(3));
    check("fullpop_head", 81'(fq_de_insn), 81'(32'h00200113));
    repeat (4) idle(1'b0);
    check("fullpop_drained", 81'(fq_count), 81'(0));

    // 4. Flush colliding with push and pop
    step(1'b1, 1'b0, 31'h20, 32'h00500293, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h22, 32'h00600313, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h24, 32'h00700393, 1'b0, 1'b1);
    check("flush_count", 81'(fq_count), 81'(0));
    check("flush_valid", 81'(fq_de_valid), 81'(0));
    check("flush_stall", 81'(fq_stall), 81'(0));
    idle(1'b0);

    // 5. Error blocks further pushes until flush
    step(1'b1, 1'b0, 31'h80, 32'h00800413, 1'b1, 1'b0);
    step(1'b1, 1'b1, 31'h82, 32'h00900493, 1'b1, 1'b0);
    step(1'b1, 1'b0, 31'h84, 32'h00a00513, 1'b1, 1'b0);
    check("blk_stall", 81'(fq_stall), 81'(1));
    check("blk_count", 81'(fq_count), 81'(2));
    repeat (3) step(1'b1, 1'b0, 31'h84, 32'h00a00513, 1'b0, 1'b0);
    check("blk_drained", 81'(fq_count), 81'(0));
    check("blk_still_stall", 81'(fq_stall), 81'(1));
    step(1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 1'b1);
    check("blk_cleared", 81'(fq_stall), 81'(0));

    // 6. Wrap: back-to-back pushes, decode never stalls
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 31'(32'h100 + k * 2), 32'h00000013 + (k << 7), 1'b0, 1'b0);
      if (fq_count > 3'd1) check("wrap_count_le1", 81'(fq_count), 81'(1));
    end
    idle(1'b0);
    check("wrap_empty", 81'(fq_count), 81'(0));

    // Random decode stalls and fetch gaps against the scoreboard
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'b0, 31'(32'h200 + k * 2),
           32'h12340000 + 32'(k), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 10; k++) idle(1'b0);
    check("final_sb_empty", 81'(sb.size()), 81'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
